// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response and data-memory signals of the load/store unit.
//   Request side : i_req, i_we, i_funct3, i_addr, i_st_data -> o_ready, o_done,
//                  o_err, o_ld_data
//   Memory side  : o_dmem_wren, o_dmem_addr, o_dmem_st_data <- i_dmem_load_data
// Modports: slave = the LSU itself, master = the pipeline/memory side driving it.
interface dmem_lsu_if;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_ready;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_ld_data;
  logic        o_dmem_wren;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_st_data;
  logic [31:0] i_dmem_load_data;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_st_data, i_dmem_load_data,
    output o_ready, o_done, o_err, o_ld_data, o_dmem_wren, o_dmem_addr, o_dmem_st_data
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_st_data, i_dmem_load_data,
    input  o_ready, o_done, o_err, o_ld_data, o_dmem_wren, o_dmem_addr, o_dmem_st_data
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit in front of a word-addressed data memory
// with a registered read address (read data arrives one cycle after address).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : dmem_lsu_if.slave -- request handshake and memory port
// One request in flight at a time. Sub-word stores are read-modify-write;
// loads are lane-extracted and sign/zero-extended.
module dmem_lsu #(
  parameter int DMEM_WORDS = 2048
) (
  input  logic      i_clk,
  input  logic      i_rst,
  dmem_lsu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ERR, WR, RD, LD, RMW_RD, RMW_WR} state_t;

  state_t      state, state_nx;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] st_q;
  logic [31:0] dmem_addr_q;
  logic        bad;
  logic        accept;

  assign accept = bus.i_req & (state == IDLE);

  // Request legality, evaluated on the live inputs at accept time.
  always_comb begin
    bad = 1'b0;
    if (bus.i_we) begin
      case (bus.i_funct3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = bus.i_addr[0];
        3'b010:  bad = |bus.i_addr[1:0];
        default: bad = 1'b1;
      endcase
    end else begin
      case (bus.i_funct3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = bus.i_addr[0];
        3'b010:         bad = |bus.i_addr[1:0];
        default:        bad = 1'b1;
      endcase
    end
    if ({2'b00, bus.i_addr[31:2]} >= 32'(DMEM_WORDS)) bad = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      f3_q        <= '0;
      lane_q      <= '0;
      st_q        <= '0;
      dmem_addr_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        f3_q        <= bus.i_funct3;
        lane_q      <= bus.i_addr[1:0];
        st_q        <= bus.i_st_data;
        dmem_addr_q <= {2'b00, bus.i_addr[31:2]};
      end
    end
  end

  // Lane extraction for loads.
  logic [31:0] rd_b, rd_h, ld_ext;
  assign rd_b = bus.i_dmem_load_data >> {lane_q, 3'b000};
  assign rd_h = bus.i_dmem_load_data >> {lane_q[1], 4'b0000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_b[7]}}, rd_b[7:0]};
      3'b001:  ld_ext = {{16{rd_h[15]}}, rd_h[15:0]};
      3'b100:  ld_ext = {24'h0, rd_b[7:0]};
      3'b101:  ld_ext = {16'h0, rd_h[15:0]};
      default: ld_ext = bus.i_dmem_load_data;
    endcase
  end

  // Merge store data into the word just read back from memory.
  logic [31:0] mask, ins, merged;
  always_comb begin
    if (f3_q[0]) begin
      mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
      ins  = {16'h0, st_q[15:0]} << {lane_q[1], 4'b0000};
    end else begin
      mask = 32'h0000_00FF << {lane_q, 3'b000};
      ins  = {24'h0, st_q[7:0]} << {lane_q, 3'b000};
    end
    merged = (bus.i_dmem_load_data & ~mask) | (ins & mask);
  end

  always_comb begin
    state_nx           = state;
    bus.o_ready        = 1'b0;
    bus.o_done         = 1'b0;
    bus.o_err          = 1'b0;
    bus.o_ld_data      = '0;
    bus.o_dmem_wren    = 1'b0;
    bus.o_dmem_st_data = '0;
    case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_req) begin
          if (bad)                                state_nx = ERR;
          else if (!bus.i_we)                     state_nx = RD;
          else if (bus.i_funct3 == 3'b010)        state_nx = WR;
          else                                    state_nx = RMW_RD;
        end
      end
      ERR: begin
        bus.o_done = 1'b1;
        bus.o_err  = 1'b1;
        state_nx   = IDLE;
      end
      WR: begin
        bus.o_dmem_wren    = 1'b1;
        bus.o_dmem_st_data = st_q;
        bus.o_done         = 1'b1;
        state_nx           = IDLE;
      end
      RD:     state_nx = LD;
      LD: begin
        bus.o_done    = 1'b1;
        bus.o_ld_data = ld_ext;
        state_nx      = IDLE;
      end
      RMW_RD: state_nx = RMW_WR;
      RMW_WR: begin
        bus.o_dmem_wren    = 1'b1;
        bus.o_dmem_st_data = merged;
        bus.o_done         = 1'b1;
        state_nx           = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.o_dmem_addr = dmem_addr_q;

endmodule

// File: tb/tb_dmem_lsu.sv
`timescale 1ns/1ps
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_lsu_if bus();
  dmem_lsu #(.DMEM_WORDS(2048)) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // Data memory model: registered read address, write on rising edge.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.o_dmem_wren) mem[bus.o_dmem_addr[11:0]] <= bus.o_dmem_st_data;
    bus.i_dmem_load_data <= mem[bus.o_dmem_addr[11:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] ld;
    logic        wren;
    logic [31:0] st;
    logic [31:0] addr;
    int          cyc;
  } exp_t;
  exp_t q[$];

  // Monitor: pops one expectation per completion pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_dmem_wren) begin
        tests++;
        if (!bus.o_done) begin
          fails++;
          $display("FAIL wren_without_done cyc=%0d got done=%b want 1", cyc, bus.o_done);
        end
      end
      if (bus.o_done) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.o_err !== e.err || bus.o_ld_data !== e.ld || bus.o_dmem_wren !== e.wren ||
              bus.o_dmem_st_data !== e.st || bus.o_dmem_addr !== e.addr || cyc != e.cyc) begin
            fails++;
            $display("FAIL %s got err=%b ld=%h wren=%b st=%h addr=%h cyc=%0d want err=%b ld=%h wren=%b st=%h addr=%h cyc=%0d",
                     e.name, bus.o_err, bus.o_ld_data, bus.o_dmem_wren, bus.o_dmem_st_data,
                     bus.o_dmem_addr, cyc, e.err, e.ld, e.wren, e.st, e.addr, e.cyc);
          end
        end
      end
    end
  end

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input bit push,
                       input logic e_err, input logic [31:0] e_ld, input logic e_wren,
                       input logic [31:0] e_st, input int lat, output int acc);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    bus.i_we = we; bus.i_funct3 = f3; bus.i_addr = a; bus.i_st_data = d; bus.i_req = 1'b1;
    while (!bus.o_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.o_ready) begin
      tests++; fails++;
      $display("FAIL %s_accept_timeout got ready=0 want 1", nm);
      bus.i_req = 1'b0; acc = -1;
      return;
    end
    acc = cyc;
    if (push) begin
      e.name = nm; e.err = e_err; e.ld = e_ld; e.wren = e_wren; e.st = e_st;
      e.addr = {2'b00, a[31:2]}; e.cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk); #1 bus.i_req = 1'b0;
  endtask

  // Loads: expected load data, no write. Stores: expected written word.
  task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    int acc;
    issue(nm, 1'b0, f3, a, 32'h0, 1'b1, 1'b0, v, 1'b0, 32'h0, 2, acc);
  endtask
  task automatic st(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] w, input int lat);
    int acc;
    issue(nm, 1'b1, f3, a, d, 1'b1, 1'b0, 32'h0, 1'b1, w, lat, acc);
  endtask
  task automatic er(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a);
    int acc;
    issue(nm, we, f3, a, 32'h5555_5555, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1, acc);
  endtask

  task automatic chk_rst_outputs(input string nm);
    tests++;
    if (bus.o_dmem_wren !== 1'b0 || bus.o_dmem_addr !== 32'h0 || bus.o_dmem_st_data !== 32'h0 ||
        bus.o_done !== 1'b0 || bus.o_err !== 1'b0 || bus.o_ld_data !== 32'h0) begin
      fails++;
      $display("FAIL %s got wren=%b addr=%h st=%h done=%b err=%b ld=%h want all zero", nm,
               bus.o_dmem_wren, bus.o_dmem_addr, bus.o_dmem_st_data, bus.o_done, bus.o_err, bus.o_ld_data);
    end
  endtask

  initial begin
    int a0, a1, w;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = 3'b0; bus.i_addr = 32'h0; bus.i_st_data = 32'h0;
    #12;
    chk_rst_outputs("reset_state");
    @(negedge clk); rst = 1'b0;
    #1;
    tests++;
    if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %b want 1", bus.o_ready); end

    st("sw_10", 3'b010, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    ld("lw_10", 3'b010, 32'h10, 32'hDEADBEEF);
    ld("lb_13", 3'b000, 32'h13, 32'hFFFFFFDE);
    ld("lbu_13", 3'b100, 32'h13, 32'h000000DE);
    ld("lh_12", 3'b001, 32'h12, 32'hFFFFDEAD);
    ld("lhu_10", 3'b101, 32'h10, 32'h0000BEEF);
    ld("lb_10", 3'b000, 32'h10, 32'hFFFFFFEF);
    st("sb_11", 3'b000, 32'h11, 32'h12345677, 32'hDEAD77EF, 2);
    st("sh_12", 3'b001, 32'h12, 32'h0000CAFE, 32'hCAFE77EF, 2);
    ld("lw_rmw", 3'b010, 32'h10, 32'hCAFE77EF);

    er("err_lw_12", 1'b0, 3'b010, 32'h12);
    er("err_sh_13", 1'b1, 3'b001, 32'h13);
    er("err_lw_2000", 1'b0, 3'b010, 32'h2000);
    er("err_ld_f3_011", 1'b0, 3'b011, 32'h10);
    er("err_sw_f3_011", 1'b1, 3'b011, 32'h10);
    ld("lw_after_err", 3'b010, 32'h10, 32'hCAFE77EF);

    // Reset in the middle of a read-modify-write: the store must be dropped.
    issue("sb_rst", 1'b1, 3'b000, 32'h10, 32'h000000AA, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, a0);
    #2 rst = 1'b1;
    #1 chk_rst_outputs("mid_rmw_reset");
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (bus.o_dmem_wren !== 1'b0) begin fails++; $display("FAIL rst_wren got %b want 0", bus.o_dmem_wren); end
    end
    rst = 1'b0;
    ld("lw_after_rst", 3'b010, 32'h10, 32'hCAFE77EF);

    // Request held while busy: LW must wait for the SW to finish.
    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b1, 1'b0, 32'h0, 1'b1, 32'h11223344, 1, a0);
    #1;
    tests++;
    if (bus.o_ready !== 1'b0) begin fails++; $display("FAIL busy_ready got %b want 0", bus.o_ready); end
    issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h11223344, 1'b0, 32'h0, 2, a1);
    tests++;
    if (a1 - a0 != 2) begin fails++; $display("FAIL held_accept_gap got %0d want 2", a1 - a0); end

    w = 0;
    while (q.size() != 0 && w < 10) begin @(negedge clk); w++; end
    #1;
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL drain got %0d pending want 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
